// File: rtl/pha_pkg.sv
// Shared types for the pulse height analyzer: FSM states and the event record
// that travels through the output FIFO.
package pha_pkg;

    localparam int PHA_DATA_W  = 16;
    localparam int PHA_TS_W    = 32;
    localparam int PHA_WIDTH_W = 12;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        WAIT_LOW,
        HOLD
    } pha_state_e;

    // One detected pulse. Field widths are the analyzer's default widths.
    typedef struct packed {
        logic signed [PHA_DATA_W-1:0] height;
        logic [PHA_TS_W-1:0]          ts;
        logic [PHA_WIDTH_W-1:0]       width;
        logic                         pileup;
    } pha_event_t;

    localparam int PHA_EVT_W = $bits(pha_event_t);

endpackage

// File: rtl/pha_event_fifo.sv
// Small synchronous event FIFO. Push and pop take effect on the clock edge.
// The head is driven from storage flops and reads as zero while empty.
module pha_event_fifo
    import pha_pkg::*;
#(
    parameter int FIFO_D = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  pha_event_t push_data_i,
    input  logic       pop_i,
    output pha_event_t head_o,
    output logic       empty_o,
    output logic       full_o
);

    localparam int AW = $clog2(FIFO_D);
    localparam int CW = AW + 1;

    pha_event_t    mem_q [FIFO_D];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(FIFO_D));
    assign do_pop  = pop_i && !empty_o;
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Event storage; contents are only meaningful behind a valid count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    // Head of queue, forced to zero when nothing is stored.
    always_comb begin
        head_o = '0;
        if (!empty_o) head_o = mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/pulse_height_analyzer.sv
// Pulse height analyzer: registers the shaped stream, detects threshold
// crossings, tracks the first-occurring peak, applies pile-up and dead-time
// rules, and queues one event per pulse for the readout logic.
// DATA_W/TS_W/WIDTH_W must match the widths of pha_event_t.
module pulse_height_analyzer
    import pha_pkg::*;
#(
    parameter int DATA_W    = PHA_DATA_W,
    parameter int TS_W      = PHA_TS_W,
    parameter int WIDTH_W   = PHA_WIDTH_W,
    parameter int MAX_WIDTH = 256,
    parameter int HOLDOFF   = 64,
    parameter int FIFO_D    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] shp_in,
    input  logic signed [DATA_W-1:0] thresh,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic signed [DATA_W-1:0] evt_height,
    output logic [TS_W-1:0]          evt_time,
    output logic [WIDTH_W-1:0]       evt_width,
    output logic                     evt_pileup,
    output logic [15:0]              drop_cnt,
    output logic                     busy
);

    localparam int HC_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    logic signed [DATA_W-1:0] s_q;
    logic [TS_W-1:0]          s_ts_q;
    logic                     s_vld_q;
    logic [TS_W-1:0]          ts_q;

    pha_state_e               state_q, state_d;
    logic signed [DATA_W-1:0] pk_q, pk_d;
    logic [TS_W-1:0]          pkt_q, pkt_d;
    logic [WIDTH_W-1:0]       width_q, width_d;
    logic [HC_W-1:0]          hcnt_q, hcnt_d;
    logic [15:0]              drop_q;

    logic                     above;
    logic                     push;
    logic                     pileup;
    pha_event_t               evt_d;
    pha_event_t               head;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     drop;

    // s_vld_q masks the first cycle after reset, when s_q holds no real sample yet.
    assign above = s_vld_q && (s_q > thresh);

    // Control state: free-running timestamp, sample-valid flag, FSM, hold counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q    <= '0;
            s_vld_q <= 1'b0;
            state_q <= IDLE;
            hcnt_q  <= '0;
        end else begin
            ts_q    <= ts_q + TS_W'(1);
            s_vld_q <= 1'b1;
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
        end
    end

    // Datapath registers: input sample with its timestamp, peak and width trackers.
    always_ff @(posedge clk) begin
        s_q     <= shp_in;
        s_ts_q  <= ts_q;
        pk_q    <= pk_d;
        pkt_q   <= pkt_d;
        width_q <= width_d;
    end

    // Next-state logic: pulse detection, peak tracking, pile-up cut-off and dead-time.
    always_comb begin
        state_d = state_q;
        pk_d    = pk_q;
        pkt_d   = pkt_q;
        width_d = width_q;
        hcnt_d  = hcnt_q;
        push    = 1'b0;
        pileup  = 1'b0;
        case (state_q)
            IDLE: begin
                if (above) begin
                    pk_d    = s_q;
                    pkt_d   = s_ts_q;
                    width_d = WIDTH_W'(1);
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (above) begin
                    width_d = width_q + WIDTH_W'(1);
                    // Strict compare keeps the first occurrence of a flat top.
                    if (s_q > pk_q) begin
                        pk_d  = s_q;
                        pkt_d = s_ts_q;
                    end
                    if (width_d == WIDTH_W'(MAX_WIDTH)) begin
                        push    = 1'b1;
                        pileup  = 1'b1;
                        state_d = WAIT_LOW;
                    end
                end else begin
                    push = 1'b1;
                    if (HOLDOFF == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                        hcnt_d  = HC_W'(HOLDOFF);
                    end
                end
            end
            WAIT_LOW: begin
                if (!above) begin
                    if (HOLDOFF == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                        hcnt_d  = HC_W'(HOLDOFF);
                    end
                end
            end
            HOLD: begin
                hcnt_d = hcnt_q - HC_W'(1);
                if (hcnt_q == HC_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Event record assembled from the post-update peak and width.
    always_comb begin
        evt_d        = '0;
        evt_d.height = PHA_DATA_W'(pk_d);
        evt_d.ts     = PHA_TS_W'(pkt_d);
        evt_d.width  = PHA_WIDTH_W'(width_d);
        evt_d.pileup = pileup;
    end

    pha_event_fifo #(
        .FIFO_D(FIFO_D)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_data_i(evt_d),
        .pop_i      (evt_ready),
        .head_o     (head),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full)
    );

    // A full FIFO pops only when the consumer is ready, so that is the only rescue.
    assign drop = push && fifo_full && !evt_ready;

    // Saturating count of events lost to a full FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else if (drop && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign evt_valid  = !fifo_empty;
    assign evt_height = DATA_W'(head.height);
    assign evt_time   = TS_W'(head.ts);
    assign evt_width  = WIDTH_W'(head.width);
    assign evt_pileup = head.pileup;
    assign drop_cnt   = drop_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_pulse_height_analyzer.sv
// Bench for pulse_height_analyzer: directed sample sequences, a pulse-level
// reference model computed from the whole sequence, and a per-cycle compare.
module tb_pulse_height_analyzer;

    localparam int DW   = 16;
    localparam int TW   = 32;
    localparam int WW   = 12;
    localparam int MAXW = 16;
    localparam int HO   = 8;
    localparam int FD   = 4;
    localparam int NMAX = 128;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic signed [DW-1:0] shp_in = '0;
    logic signed [DW-1:0] thresh = 16'sd100;
    logic                 evt_ready = 1'b0;
    logic                 evt_valid;
    logic signed [DW-1:0] evt_height;
    logic [TW-1:0]        evt_time;
    logic [WW-1:0]        evt_width;
    logic                 evt_pileup;
    logic [15:0]          drop_cnt;
    logic                 busy;

    pulse_height_analyzer #(
        .DATA_W(DW), .TS_W(TW), .WIDTH_W(WW),
        .MAX_WIDTH(MAXW), .HOLDOFF(HO), .FIFO_D(FD)
    ) dut (
        .clk(clk), .rst(rst), .shp_in(shp_in), .thresh(thresh),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_height(evt_height), .evt_time(evt_time), .evt_width(evt_width),
        .evt_pileup(evt_pileup), .drop_cnt(drop_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Scenario description
    int x   [NMAX];
    bit rdy [NMAX];
    int n_smp;
    int thr;

    // Expected pulses: emit = cycle whose ending edge makes the event visible
    typedef struct {
        int h;
        int t;
        int w;
        bit p;
        int emit;
        int bz_lo;
        int bz_hi;
    } ev_t;

    ev_t evs[$];
    ev_t mq[$];
    int  md_drops;
    int  cur_k;
    bit  chk_en = 1'b0;
    bit  m_full, m_pop, m_bz;

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cur_k);
        end
    endtask

    task automatic clear_stim(input int n, input int t);
        n_smp = n;
        thr   = t;
        for (int k = 0; k < NMAX; k++) begin
            x[k]   = 0;
            rdy[k] = 1'b1;
        end
    endtask

    task automatic set_run(input int s, input int len, input int v);
        for (int k = s; k < s + len; k++) x[k] = v;
    endtask

    // Pulse-level reference: find each qualifying run, cut it at MAXW, take the
    // first maximum, and start the next search after the dead-time.
    task automatic build_model();
        int  ready_at, i, j, w;
        ev_t e;
        evs.delete();
        ready_at = 0;
        for (int guard = 0; guard < NMAX; guard++) begin
            i = ready_at;
            while (i < n_smp && x[i] <= thr) i++;
            if (i >= n_smp) break;
            j = i;
            while (j < n_smp && x[j] > thr) j++;
            if (j - i >= MAXW) begin
                w = MAXW; e.p = 1'b1; e.emit = i + MAXW;
            end else begin
                w = j - i; e.p = 1'b0; e.emit = j + 1;
            end
            e.w = w;
            e.h = x[i];
            e.t = i;
            for (int m = i + 1; m < i + w; m++) begin
                if (x[m] > e.h) begin
                    e.h = x[m];
                    e.t = m;
                end
            end
            ready_at = j + 1 + HO;
            e.bz_lo  = i + 1;
            e.bz_hi  = ready_at - 1;
            evs.push_back(e);
            if (j >= n_smp) break;
        end
    endtask

    task automatic run_scenario();
        build_model();
        @(negedge clk);
        rst       = 1'b1;
        thresh    = DW'(thr);
        shp_in    = '0;
        evt_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mq.delete();
        md_drops = 0;
        for (int k = 0; k < n_smp; k++) begin
            if (k > 0) @(negedge clk);
            shp_in    = DW'(x[k]);
            evt_ready = rdy[k];
            cur_k     = k;
            if (k == 0) begin
                rst    = 1'b0;
                chk_en = 1'b1;
            end
        end
        @(negedge clk);
        chk_en = 1'b0;
    endtask

    // Per-cycle compare: advance the FIFO model at each edge, then check the DUT.
    always begin
        @(posedge clk);
        if (chk_en) begin
            m_full = (mq.size() == FD);
            m_pop  = (mq.size() > 0) && evt_ready;
            if (m_pop) void'(mq.pop_front());
            foreach (evs[n]) begin
                if (evs[n].emit == cur_k) begin
                    if (m_full && !m_pop) begin
                        if (md_drops < 65535) md_drops++;
                    end else begin
                        mq.push_back(evs[n]);
                    end
                end
            end
            m_bz = 1'b0;
            foreach (evs[n]) if (cur_k >= evs[n].bz_lo && cur_k <= evs[n].bz_hi) m_bz = 1'b1;
            #1;
            check("evt_valid", evt_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                check("evt_height", evt_height, mq[0].h);
                check("evt_time",   evt_time,   mq[0].t);
                check("evt_width",  evt_width,  mq[0].w);
                check("evt_pileup", evt_pileup, mq[0].p);
            end
            check("drop_cnt", drop_cnt, md_drops);
            check("busy",     busy,     m_bz);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset in the middle of a pulse
        @(negedge clk);
        rst = 1'b1; thresh = 16'sd100; shp_in = '0; evt_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; shp_in = 16'sd300;
        repeat (4) @(negedge clk);
        check("t1_busy_before_rst", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("t1_rst_valid",  evt_valid,  0);
        check("t1_rst_busy",   busy,       0);
        check("t1_rst_drop",   drop_cnt,   0);
        check("t1_rst_height", evt_height, 0);
        check("t1_rst_time",   evt_time,   0);
        check("t1_rst_width",  evt_width,  0);
        check("t1_rst_pileup", evt_pileup, 0);
        shp_in = '0;
        clear_stim(24, 100);
        run_scenario();
        check("t1_m_count", evs.size(), 0);

        // 2: basic pulse
        clear_stim(20, 100);
        x[1] = 50; x[2] = 150; x[3] = 300; x[4] = 300; x[5] = 200; x[6] = 90;
        run_scenario();
        check("t2_m_count", evs.size(), 1);
        if (evs.size() == 1) begin
            check("t2_m_height", evs[0].h, 300);
            check("t2_m_time",   evs[0].t, 3);
            check("t2_m_width",  evs[0].w, 4);
            check("t2_m_pileup", evs[0].p, 0);
            check("t2_m_emit",   evs[0].emit, 7);
        end

        // 3a: second pulse inside dead-time
        clear_stim(45, 100);
        set_run(10, 10, 200);
        set_run(25, 3, 300);
        run_scenario();
        check("t3a_m_count", evs.size(), 1);
        if (evs.size() == 1) begin
            check("t3a_m_height", evs[0].h, 200);
            check("t3a_m_width",  evs[0].w, 10);
        end

        // 3b: second pulse right after dead-time
        clear_stim(45, 100);
        set_run(10, 10, 200);
        set_run(29, 3, 300);
        run_scenario();
        check("t3b_m_count", evs.size(), 2);
        if (evs.size() == 2) begin
            check("t3b_m_time",  evs[1].t, 29);
            check("t3b_m_width", evs[1].w, 3);
        end

        // 4: pile-up on a long plateau
        clear_stim(70, 100);
        set_run(5, 40, 500);
        set_run(50, 2, 300);
        set_run(54, 2, 250);
        run_scenario();
        check("t4_m_count", evs.size(), 2);
        if (evs.size() == 2) begin
            check("t4_m_height", evs[0].h, 500);
            check("t4_m_width",  evs[0].w, 16);
            check("t4_m_pileup", evs[0].p, 1);
            check("t4_m_emit",   evs[0].emit, 21);
            check("t4_m_next_t", evs[1].t, 54);
        end

        // 5: FIFO overflow, then drain in order
        clear_stim(80, 100);
        for (int p = 0; p < 6; p++) set_run(2 + 12 * p, 2, 110 + 10 * p);
        for (int k = 0; k < 70; k++) rdy[k] = 1'b0;
        run_scenario();
        check("t5_m_count", evs.size(), 6);
        check("t5_m_drops", md_drops, 2);
        check("t5_drop_final", drop_cnt, 2);
        check("t5_valid_final", evt_valid, 0);

        // 6: signed, strict threshold
        clear_stim(20, 100);
        x[2] = -32768; x[3] = 100; x[5] = 101;
        run_scenario();
        check("t6_m_count", evs.size(), 1);
        if (evs.size() == 1) begin
            check("t6_m_width",  evs[0].w, 1);
            check("t6_m_height", evs[0].h, 101);
            check("t6_m_time",   evs[0].t, 5);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
